gf2_rref_arbiter: RTL
=====================

Name: gf2_rref_arbiter

Overview:
Shares a single gf2_rref engine among CLIENTS independent requesters, one matrix job at a time. Each client submits an augmented GF(2) matrix over a valid/ready handshake. The arbiter picks a client round-robin, latches its matrix, launches the engine, waits for completion or a watchdog timeout, and returns the RREF result to that client over a valid/ready response handshake. It sits between the per-machine solver front-ends and the one elimination engine instance.

Parameters:
CLIENTS, 4, number of requesters (>=2)
ROWS, 8, matrix rows; must match the engine instance
COLS, 11, matrix columns (A plus B); must match the engine instance
TIMEOUT, 1024, max cycles in WAIT before the job is aborted (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  CLIENTS  per-client job request
req_ready  out  CLIENTS  per-client accept, one-hot or zero
req_aug  in  CLIENTS x ROWS x COLS  per-client augmented matrix
resp_valid  out  CLIENTS  per-client result valid, one-hot or zero
resp_ready  in  CLIENTS  per-client result accept
resp_rref  out  ROWS x COLS  result matrix, shared by all clients
resp_timeout  out  1  qualifies resp_valid: job aborted, resp_rref is all zero
grant_id  out  clog2(CLIENTS)  client currently owning the engine
busy  out  1  high in every state except IDLE
eng_rst_n  out  1  engine synchronous active-low reset
eng_start  out  1  engine start pulse
eng_aug  out  ROWS x COLS  engine matrix input (registered copy)
eng_ready  in  1  engine completion pulse
eng_rref  in  ROWS x COLS  engine result

Behaviour:
- Reset (async, rst=1): state=IDLE; last_grant=CLIENTS-1, so client 0 has first priority; aug_q, rref_q, resp_timeout, grant_id, wait counter all 0; rst_done_q=0. req_ready, resp_valid, eng_start, busy are 0 while in reset.
- eng_rst_n = rst_done_q AND (state != ABORT). rst_done_q is set on the first clk edge after rst deasserts. The engine therefore sees at least one reset edge after every arbiter reset.
- FSM states: IDLE, LAUNCH, WAIT, ABORT, RESPOND.
- IDLE: if any req_valid, select the first asserted client scanning last_grant+1, +2, … with wrap modulo CLIENTS. In that same cycle, drive req_ready[sel]=1 combinationally. On the edge, latch aug_q=req_aug[sel] and grant_id=sel, then go to LAUNCH. With no request, stay in IDLE. Only one accept per job.
- LAUNCH: eng_start=1 for exactly this one cycle; eng_aug=aug_q, held stable from LAUNCH to the end of the job; clear the wait counter; go to WAIT.
- WAIT: the counter increments each cycle.
  - If eng_ready: rref_q=eng_rref, resp_timeout=0, go to RESPOND.
  - Else if counter==TIMEOUT-1: go to ABORT.
  - If eng_ready and the timeout coincide, eng_ready wins.
- ABORT: one cycle with eng_rst_n=0 so the engine returns to its initial state. On the edge, rref_q=0, resp_timeout=1, go to RESPOND.
- RESPOND: resp_valid[grant_id]=1, and resp_rref=rref_q stays stable. When resp_ready[grant_id] is high on an edge: last_grant=grant_id, go to IDLE. resp_ready from other clients is ignored.
- The earliest re-accept is the cycle after the response handshake (IDLE). Minimum job turnaround is 1 accept + 1 launch + engine latency + 1 respond.
- eng_ready outside WAIT is ignored. A req_valid that drops before acceptance is legal; no job is recorded for it.
- Counter width is clog2(TIMEOUT+1) and it never wraps.
- The round-robin pointer updates only on response completion, including timeout completions.

Test Plan:
- ROWS=3, COLS=4 with the real engine. Client 1 submits {1100,1010,0000} (row0 first) -> one-cycle req_ready[1], a one-cycle eng_start, then resp_valid[1] with resp_rref={1010,0110,0000} and resp_timeout=0.
- Already-reduced input {1001,0101,0011} from client 0 -> resp_rref identical to input; the job is bracketed by busy.
- Clients 0, 2 and 3 all hold req_valid from reset, with resp_ready tied high -> grant order 0, 2, 3, 0, 2, 3. No client is starved, and req_ready is never multi-hot.
- A stub engine never asserts eng_ready, with TIMEOUT=16 -> exactly 16 WAIT cycles, one eng_rst_n=0 cycle, then resp_valid with resp_timeout=1 and resp_rref=0. The next job completes normally.
- resp_ready is held 0 for 5 cycles, and another client's req_valid asserts meanwhile -> resp_valid and resp_rref stay stable, with no new req_ready until 1 cycle after the handshake.
- rst pulsed asynchronously mid-WAIT -> outputs clear immediately, and eng_rst_n stays 0 through the first post-reset edge. The subsequent request from client 0 completes correctly.

Source files
------------

// File: rtl/gf2_rref_arbiter.sv
// gf2_rref_arbiter
// Shares one gf2_rref elimination engine among CLIENTS requesters, one job at a
// time. A client is picked round-robin, its augmented matrix is latched and
// handed to the engine, and the result (or a zero matrix flagged as timed out
// when the engine does not finish within TIMEOUT cycles) is returned to that
// client over a valid/ready response handshake.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/ready    per-client job handshake (ready is one-hot or zero)
//   req_aug            per-client augmented matrix, row-major
//   resp_valid/ready   per-client result handshake (valid is one-hot or zero)
//   resp_rref          result matrix, shared by all clients
//   resp_timeout       qualifies resp_valid: job was aborted, resp_rref is zero
//   grant_id           client currently owning the engine
//   busy               high whenever a job is in flight
//   eng_rst_n          engine synchronous active-low reset
//   eng_start          one-cycle engine start pulse
//   eng_aug            matrix presented to the engine, stable for the whole job
//   eng_ready/eng_rref engine completion pulse and result
module gf2_rref_arbiter #(
  parameter int CLIENTS = 4,
  parameter int ROWS    = 8,
  parameter int COLS    = 11,
  parameter int TIMEOUT = 1024,
  localparam int GW     = $clog2(CLIENTS),
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CLIENTS-1:0]                    req_valid,
  output logic [CLIENTS-1:0]                    req_ready,
  input  logic [CLIENTS-1:0][ROWS-1:0][COLS-1:0] req_aug,
  output logic [CLIENTS-1:0]                    resp_valid,
  input  logic [CLIENTS-1:0]                    resp_ready,
  output logic [ROWS-1:0][COLS-1:0]             resp_rref,
  output logic                                  resp_timeout,
  output logic [GW-1:0]                         grant_id,
  output logic                                  busy,
  output logic                                  eng_rst_n,
  output logic                                  eng_start,
  output logic [ROWS-1:0][COLS-1:0]             eng_aug,
  input  logic                                  eng_ready,
  input  logic [ROWS-1:0][COLS-1:0]             eng_rref
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ABORT   = 3'd3,
    ST_RESPOND = 3'd4
  } state_t;

  state_t                    state_r;
  state_t                    state_n_s;
  logic [GW-1:0]             last_grant_r;
  logic                      rst_done_r;
  logic [ROWS-1:0][COLS-1:0] aug_r;
  logic [ROWS-1:0][COLS-1:0] rref_r;
  logic [CW-1:0]             wait_cnt_r;
  logic [GW-1:0]             sel_s;
  logic [GW-1:0]             scan_idx_s;
  logic                      sel_found_s;
  logic                      accept_s;
  logic                      timeout_hit_s;

  // Round-robin pick: first requesting client after the last served one.
  always_comb begin
    sel_s       = '0;
    scan_idx_s  = '0;
    sel_found_s = 1'b0;
    for (int i = 1; i <= CLIENTS; i++) begin
      scan_idx_s = GW'((int'(last_grant_r) + i) % CLIENTS);
      if (!sel_found_s && req_valid[scan_idx_s]) begin
        sel_found_s = 1'b1;
        sel_s       = scan_idx_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  assign timeout_hit_s = (wait_cnt_r == CW'(TIMEOUT - 1));

  // Next-state decode; eng_ready takes priority over a coinciding timeout.
  always_comb begin
    state_n_s = state_r;
    accept_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sel_found_s) begin
          accept_s  = 1'b1;
          state_n_s = ST_LAUNCH;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_LAUNCH: state_n_s = ST_WAIT;
      ST_WAIT: begin
        if (eng_ready) begin
          state_n_s = ST_RESPOND;
        end else if (timeout_hit_s) begin
          state_n_s = ST_ABORT;
        end else begin
          state_n_s = ST_WAIT;
        end
      end
      ST_ABORT: state_n_s = ST_RESPOND;
      ST_RESPOND: begin
        if (resp_ready[grant_id]) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_RESPOND;
        end
      end
      default: state_n_s = ST_IDLE;
    endcase
  end

  // Accept strobe to the selected client; held off while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (accept_s && !rst) begin
      req_ready[sel_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Result strobe to the owning client.
  always_comb begin
    resp_valid = '0;
    if (state_r == ST_RESPOND) begin
      resp_valid[grant_id] = 1'b1;
    end else begin
      resp_valid = '0;
    end
  end

  assign busy      = (state_r != ST_IDLE);
  assign eng_start = (state_r == ST_LAUNCH);
  // The engine is held in reset until the first edge after an arbiter reset,
  // and for the single ABORT cycle that recovers it from a hung job.
  assign eng_rst_n = rst_done_r && (state_r != ST_ABORT);
  assign eng_aug   = aug_r;
  assign resp_rref = rref_r;

  // Control state, grant ownership and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= GW'(CLIENTS - 1);
      grant_id     <= '0;
      rst_done_r   <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      rst_done_r <= 1'b1;
      if (accept_s) begin
        grant_id <= sel_s;
      end
      // Pointer moves only on a completed response, timed out or not.
      if ((state_r == ST_RESPOND) && resp_ready[grant_id]) begin
        last_grant_r <= grant_id;
      end
    end
  end

  // Job datapath: latched matrix, captured result, timeout flag, wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aug_r        <= '0;
      rref_r       <= '0;
      resp_timeout <= 1'b0;
      wait_cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            aug_r <= req_aug[sel_s];
          end
        end
        ST_LAUNCH: wait_cnt_r <= '0;
        ST_WAIT: begin
          // Saturating: the counter never wraps.
          if (wait_cnt_r < CW'(TIMEOUT)) begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
          end
          if (eng_ready) begin
            rref_r       <= eng_rref;
            resp_timeout <= 1'b0;
          end
        end
        ST_ABORT: begin
          rref_r       <= '0;
          resp_timeout <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
